approx_err_monitor: RTL
=======================

# approx_err_monitor

Error-metric collector sitting directly downstream of the 32-bit approximate adder (HEAA family). It consumes the operands and the adder's 33-bit approximate sum. Over a window of 2^LOG2_N accepted samples it accumulates:
- the number of erroneous results,
- the sum of error distances,
- the maximum error distance.

Its results feed the characterisation flow used to rank approximate adder configurations.

## Interface
Parameters:
- WIDTH, 32, operand width; sums are WIDTH+1 bits.
- LOG2_N, 10, log2 of samples per measurement window (1..16).

Ports (clock is `clk`; reset is `rst_n`, synchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a new window (honoured only in IDLE)
- in_valid  in  1  sample present on a/b/approx_sum
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  WIDTH  operand A given to the adder
- b  in  WIDTH  operand B given to the adder
- approx_sum  in  WIDTH+1  approximate adder result for a, b
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse; results valid and frozen
- err_count  out  LOG2_N+1  samples with approx_sum != a+b
- err_dist_sum  out  WIDTH+1+LOG2_N  sum of |exact - approx|
- max_err_dist  out  WIDTH+1  largest |exact - approx|
- sample_count  out  LOG2_N+1  samples accepted in the current window

## Operation
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the edge that accepts the 2^LOG2_N-th sample.
  - DRAIN -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle.
- start in IDLE:
  - clears err_count, err_dist_sum, max_err_dist and sample_count on the same edge.
  - start in RUN, DRAIN or DONE is ignored.
- Handshake:
  - in_ready = (state == RUN); it is a function of registered state only.
  - A sample is accepted on any edge where in_valid && in_ready.
  - in_valid may drop at any time; gaps are allowed and do not count toward the window.
- Stage 1 (registered on accept):
  - exact = a + b, computed at WIDTH+1 bits with no truncation.
  - ed = |exact - approx_sum|, unsigned, WIDTH+1 bits.
  - err = (ed != 0).
  - A stage-1 valid bit is also registered.
- Stage 2 (when stage-1 valid):
  - err_count += err.
  - err_dist_sum += ed, zero-extended.
  - max_err_dist = max(max_err_dist, ed).
- sample_count increments on the accept edge itself, not in the pipeline.
- Widths guarantee no overflow: a full window of maximal ed fits in err_dist_sum.
- Results hold their values in DONE and IDLE until the next accepted start.

## Timing
- Reset values:
  - state IDLE, stage-1 valid 0.
  - in_ready 0, busy 0, done 0.
  - all four counters/accumulators 0.
- rst_n low on any edge, including mid-RUN or mid-DRAIN:
  - everything returns to reset values on that edge.
  - in-flight stage-1 data is discarded.
- Latency: a sample accepted on edge E is reflected in the accumulators after edge E+1.
- Last sample accepted on edge E:
  - DRAIN during cycle E..E+1.
  - DONE during E+1..E+2, with done=1 for exactly that cycle.
  - All accumulators are final whenever done=1.
- in_ready falls in the cycle after the last accepting edge, so no sample beyond 2^LOG2_N is ever taken.
- start together with in_valid in IDLE: the window opens, but no sample is accepted until the first RUN cycle.

## Structure
- Shared package approx_pkg holds:
  - WIDTH default.
  - State enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, approx_err_dist. It is the combinational exact-sum and absolute-difference unit (inputs a, b, approx_sum; outputs ed, err). It is instantiated once, ahead of the stage-1 registers.
- FSM, counters and accumulators live in the top module.

## Test plan
- **Zero-error window.** LOG2_N=2; start; 4 samples with approx_sum=a+b, e.g. (5,7,12).
  - Expect err_count=0, err_dist_sum=0, max_err_dist=0, sample_count=4.
  - done pulses exactly once, 2 cycles after the 4th accept.
- **Mixed errors.** LOG2_N=2; samples (1,1,1), (0xFF,1,0xFF), (3,5,0xF), (0,0,0).
  - Expect err_count=3, err_dist_sum=9, max_err_dist=7.
- **Extremes.** a=b=0xFFFFFFFF, approx_sum=0.
  - Expect ed = max_err_dist = 0x1_FFFF_FFFE.
  - Then approx_sum=0x1_FFFF_FFFF with a=b=0: ed=0x1_FFFF_FFFF (approx > exact path); max updates.
- **Bubbles and ignored start.** in_valid toggled 1,0,0,1,...; start pulsed during RUN.
  - Only valid cycles count; the window is not restarted.
  - busy stays 1 until DONE.
  - in_ready=0 from the cycle after the 4th accept.
- **Reset mid-run.** Reset after 2 accepts: rst_n=0 for one edge.
  - All outputs go to 0 and state is IDLE.
  - A following start and 4 clean samples give err_count=0.
- **Back-to-back windows.** start asserted in the first IDLE cycle after done.
  - Accumulators clear on that edge.
  - The second window's results are independent of the first.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder error monitor.
// Holds the default operand width and the monitor's state encoding.
package approx_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/approx_err_dist.sv
// Combinational exact-sum and absolute error distance for one adder sample.
// The exact sum keeps the carry-out so no result is ever truncated.
module approx_err_dist
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   ed,
  output logic             err
);

  logic [WIDTH:0] exact;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    // Subtract the smaller from the larger so the distance stays unsigned.
    if (exact >= approx_sum) begin
      ed = exact - approx_sum;
    end else begin
      ed = approx_sum - exact;
    end
    err = |ed;
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics collector for an approximate adder.
// Samples pass through one register stage before being folded into the accumulators.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LOG2_N = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [WIDTH:0]           approx_sum,
  output logic                     busy,
  output logic                     done,
  output logic [LOG2_N:0]          err_count,
  output logic [WIDTH+LOG2_N:0]    err_dist_sum,
  output logic [WIDTH:0]           max_err_dist,
  output logic [LOG2_N:0]          sample_count,
  output logic [1:0]               dbg_state
);

  localparam int CW = LOG2_N + 1;
  localparam int SW = WIDTH + 1 + LOG2_N;
  localparam int N  = 1 << LOG2_N;

  // Handshake: a sample moves on every rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, so it never combinationally
  // follows in_valid, and the producer may drop in_valid at any time.

  state_e          state_q, state_d;
  logic            s1_valid_q;
  logic [WIDTH:0]  s1_ed_q;
  logic            s1_err_q;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic [SW-1:0]   err_dist_sum_q, err_dist_sum_d;
  logic [WIDTH:0]  max_err_dist_q, max_err_dist_d;
  logic [CW-1:0]   sample_count_q, sample_count_d;

  logic [WIDTH:0]  ed;
  logic            err;
  logic            accept;
  logic            last_accept;
  logic            start_clr;

  approx_err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .ed         (ed),
    .err        (err)
  );

  assign in_ready    = (state_q == RUN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_count_q == CW'(N - 1));
  assign start_clr   = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_accept) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_count_d    = err_count_q;
    err_dist_sum_d = err_dist_sum_q;
    max_err_dist_d = max_err_dist_q;
    sample_count_d = sample_count_q;
    if (start_clr) begin
      err_count_d    = '0;
      err_dist_sum_d = '0;
      max_err_dist_d = '0;
      sample_count_d = '0;
    end else begin
      // The window length is counted at the accept edge; stats trail by one cycle.
      if (accept) sample_count_d = sample_count_q + CW'(1);
      if (s1_valid_q) begin
        err_count_d    = err_count_q + CW'(s1_err_q);
        err_dist_sum_d = err_dist_sum_q + SW'(s1_ed_q);
        if (s1_ed_q > max_err_dist_q) max_err_dist_d = s1_ed_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_valid_q     <= 1'b0;
      s1_ed_q        <= '0;
      s1_err_q       <= 1'b0;
      err_count_q    <= '0;
      err_dist_sum_q <= '0;
      max_err_dist_q <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= accept;
      if (accept) begin
        s1_ed_q  <= ed;
        s1_err_q <= err;
      end
      err_count_q    <= err_count_d;
      err_dist_sum_q <= err_dist_sum_d;
      max_err_dist_q <= max_err_dist_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign err_count    = err_count_q;
  assign err_dist_sum = err_dist_sum_q;
  assign max_err_dist = max_err_dist_q;
  assign sample_count = sample_count_q;
  assign dbg_state    = state_q;

endmodule
